// File: rtl/ccip_intr_err_gen_pkg.sv
// Shared types for the CCI-P interrupt/error generator: minimal CCI-P port structs, CSR map, engine types.
// Latency: none (types, constants and a pure header-builder function only).
// Backpressure: n/a; the c1 almost-full flag lives in t_if_ccip_Rx.
package ccip_intr_err_gen_pkg;

  // ---- Minimal CCI-P port types (only the fields this AFU touches are meaningful) ----
  typedef logic [8:0] t_ccip_tid;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    t_ccip_tid   tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [71:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef struct packed {
    logic [5:0]   rsvd1;
    t_ccip_c1_req req_type;
    logic [61:0]  rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_ReqIntrHdr;

  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqIntrHdr hdr;
    logic [511:0]        data;
    logic                valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  // ---- CSR map (32-bit word addresses) ----
  localparam logic [15:0] CSR_DFH     = 16'h0000;
  localparam logic [15:0] CSR_ID_L    = 16'h0002;
  localparam logic [15:0] CSR_ID_H    = 16'h0004;
  localparam logic [15:0] CSR_SCRATCH = 16'h0020;
  localparam logic [15:0] CSR_TRIG    = 16'h0028;
  localparam logic [15:0] CSR_GAP     = 16'h0030;
  localparam logic [15:0] CSR_STATUS  = 16'h0038;
  localparam logic [15:0] CSR_DROP    = 16'h0040;

  // DFH: feature type AFU in [63:60], end-of-list in [40]
  localparam logic [63:0] DFH_VAL  = 64'h1000_0100_0000_0000;
  // DROP reset: enabled, targeting word address 0x0050
  localparam logic [16:0] DROP_RST = 17'h1_0050;

  // ---- Interrupt engine ----
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} t_eng_state;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] count;
  } t_intr_req;

  function automatic t_ccip_c1_ReqIntrHdr ccip_genInterrupt(input logic [1:0] id);
    t_ccip_c1_ReqIntrHdr hdr;
    hdr          = '0;
    hdr.req_type = eREQ_INTR;
    hdr.id       = id;
    return hdr;
  endfunction

endpackage

// File: rtl/ccip_intr_req_fifo.sv
// Synchronous request FIFO (power-of-2 depth) holding queued interrupt bursts.
// Latency: push visible to the pop side the cycle after it is written.
// Backpressure: push ignored when full (full judged on pre-cycle level), pop ignored when empty.
module ccip_intr_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage write; contents need no reset since level gates every read
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ccip_intr_err_gen.sv
// CCI-P AFU: MMIO CSRs plus a queued engine issuing spaced interrupt bursts; can drop one MMIO read address.
// Latency: MMIO read response 1 cycle; TRIG write at t -> first interrupt registered at t+2.
// Backpressure: c1TxAlmFull holds the engine in ISSUE; TRIG writes to a full queue are dropped (OVF).
module ccip_intr_err_gen
  import ccip_intr_err_gen_pkg::*;
#(
  parameter logic [63:0] AFU_ID_H   = 64'h5c1e_a3c4_2bfb_4e2a,
  parameter logic [63:0] AFU_ID_L   = 64'habf4_13c1_e125_41b0,
  parameter int          NUM_INTR   = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 16
) (
  input  logic        Clk_400,
  input  logic        SoftReset_n,
  input  t_if_ccip_Rx cp2af_sRxPort,
  output t_if_ccip_Tx af2cp_sTxPort
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]      w_addr;
  logic [63:0]      w_wdat;
  logic             w_wr, w_rd, w_almfull;
  logic [1:0]       w_trig_id;
  logic [7:0]       w_trig_cnt;
  logic             w_trig_wr, w_trig_bad, w_push, w_pop, w_send;
  logic             w_full, w_empty, w_drop_hit;
  logic [LVL_W-1:0] w_level;
  t_intr_req        w_push_dat, w_pop_dat;
  logic [63:0]      w_status, w_rd_dat;
  logic             w_unused;

  logic [63:0]      r_scratch, r_trig;
  logic [CNT_W-1:0] r_gap, r_issued;
  logic             r_ovf, r_badid, r_drop_en;
  logic [15:0]      r_drop_addr;

  t_eng_state       r_state, w_state_nxt;
  logic [1:0]       r_id, w_id_nxt;
  logic [7:0]       r_remain, w_remain_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

  logic                r_c1_vld, r_c2_vld;
  t_ccip_c1_ReqIntrHdr r_c1_hdr;
  t_ccip_tid           r_c2_tid;
  logic [63:0]         r_c2_dat;

  assign w_addr     = cp2af_sRxPort.c0.hdr.address;
  assign w_wdat     = cp2af_sRxPort.c0.data[63:0];
  assign w_wr       = cp2af_sRxPort.c0.mmioWrValid;
  assign w_rd       = cp2af_sRxPort.c0.mmioRdValid;
  assign w_almfull  = cp2af_sRxPort.c1TxAlmFull;
  assign w_unused   = ^cp2af_sRxPort;

  // A zero burst count is promoted to one so the engine never sees an empty burst
  assign w_trig_id  = w_wdat[1:0];
  assign w_trig_cnt = (w_wdat[15:8] == 8'd0) ? 8'd1 : w_wdat[15:8];
  assign w_trig_wr  = w_wr && (w_addr == CSR_TRIG);
  assign w_trig_bad = (int'(w_trig_id) >= NUM_INTR);
  assign w_push     = w_trig_wr && !w_trig_bad && !w_full;
  assign w_push_dat = '{id: w_trig_id, count: w_trig_cnt};
  assign w_drop_hit = r_drop_en && (w_addr == r_drop_addr);

  ccip_intr_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(t_intr_req))
  ) u_req_fifo (
    .i_clk      (Clk_400),
    .i_rst_n    (SoftReset_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_pop_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  // CSR writes, sticky error flags and the saturating issued counter
  always_ff @(posedge Clk_400) begin
    if (!SoftReset_n) begin
      r_scratch   <= '0;
      r_trig      <= '0;
      r_gap       <= '0;
      r_issued    <= '0;
      r_ovf       <= 1'b0;
      r_badid     <= 1'b0;
      r_drop_en   <= DROP_RST[16];
      r_drop_addr <= DROP_RST[15:0];
    end else begin
      if (w_wr && (w_addr == CSR_STATUS)) r_issued <= '0;
      else if (w_send && !(&r_issued))    r_issued <= r_issued + 1'b1;
      if (w_wr) begin
        case (w_addr)
          CSR_SCRATCH: r_scratch <= w_wdat;
          CSR_TRIG: begin
            r_trig <= w_wdat;
            if (w_trig_bad)  r_badid <= 1'b1;
            else if (w_full) r_ovf   <= 1'b1;
          end
          CSR_GAP:     r_gap <= w_wdat[CNT_W-1:0];
          CSR_STATUS: begin
            r_ovf   <= 1'b0;
            r_badid <= 1'b0;
          end
          CSR_DROP: begin
            r_drop_en   <= w_wdat[16];
            r_drop_addr <= w_wdat[15:0];
          end
          default: ;
        endcase
      end
    end
  end

  // STATUS word and MMIO read mux
  always_comb begin
    w_status               = '0;
    w_status[CNT_W-1:0]    = r_issued;
    w_status[32]           = (r_state != IDLE);
    w_status[33]           = r_ovf;
    w_status[34]           = r_badid;
    w_status[39:36]        = 4'(w_level);
    case (w_addr)
      CSR_DFH:     w_rd_dat = DFH_VAL;
      CSR_ID_L:    w_rd_dat = AFU_ID_L;
      CSR_ID_H:    w_rd_dat = AFU_ID_H;
      CSR_SCRATCH: w_rd_dat = r_scratch;
      CSR_TRIG:    w_rd_dat = r_trig;
      CSR_GAP:     w_rd_dat = 64'(r_gap);
      CSR_STATUS:  w_rd_dat = w_status;
      CSR_DROP:    w_rd_dat = {47'd0, r_drop_en, r_drop_addr};
      default:     w_rd_dat = '0;
    endcase
  end

  // Engine state register
  always_ff @(posedge Clk_400) begin
    if (!SoftReset_n) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_remain  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_id      <= w_id_nxt;
      r_remain  <= w_remain_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Engine next-state: pop a burst, send one interrupt per non-almost-full cycle, pace with GAP
  always_comb begin
    w_state_nxt   = r_state;
    w_id_nxt      = r_id;
    w_remain_nxt  = r_remain;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pop         = 1'b0;
    w_send        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_id_nxt     = w_pop_dat.id;
          w_remain_nxt = w_pop_dat.count;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!w_almfull) begin
          w_send       = 1'b1;
          w_remain_nxt = r_remain - 1'b1;
          if (r_gap != '0) begin
            w_state_nxt   = WAIT;
            w_gap_cnt_nxt = r_gap;
          end else if (r_remain > 8'd1) begin
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT: begin
        if (r_gap_cnt[CNT_W-1:1] == '0) begin
          w_state_nxt = (r_remain != 8'd0) ? ISSUE : IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered c1 interrupt and c2 MMIO response channels
  always_ff @(posedge Clk_400) begin
    if (!SoftReset_n) begin
      r_c1_vld <= 1'b0;
      r_c1_hdr <= '0;
      r_c2_vld <= 1'b0;
      r_c2_tid <= '0;
      r_c2_dat <= '0;
    end else begin
      r_c1_vld <= w_send;
      r_c1_hdr <= w_send ? ccip_genInterrupt(r_id) : '0;
      r_c2_vld <= w_rd && !w_drop_hit;
      r_c2_tid <= cp2af_sRxPort.c0.hdr.tid;
      r_c2_dat <= w_rd ? w_rd_dat : '0;
    end
  end

  // Drive the Tx port; c0 stays idle
  always_comb begin
    af2cp_sTxPort                = '0;
    af2cp_sTxPort.c1.hdr         = r_c1_hdr;
    af2cp_sTxPort.c1.valid       = r_c1_vld;
    af2cp_sTxPort.c2.hdr.tid     = r_c2_tid;
    af2cp_sTxPort.c2.mmioRdValid = r_c2_vld;
    af2cp_sTxPort.c2.data        = r_c2_dat;
  end

endmodule
